// File: rtl/accum_bank_if.sv
// Operation, read and flag signals of the accumulator bank, bundled so that
// client blocks can pass a single port instead of nine loose wires.
interface accum_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                in_valid;
    logic [CW-1:0]       in_chan;
    logic [1:0]          in_op;
    logic [WIDTH-1:0]    in_arg;
    logic                sat_en;
    logic [CW-1:0]       rd_chan;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS-1:0] ovf;
    logic                ovf_clear;

    modport master (
        output in_valid, in_chan, in_op, in_arg, sat_en, rd_chan, ovf_clear,
        input  rd_data, ovf
    );

    modport slave (
        input  in_valid, in_chan, in_op, in_arg, sat_en, rd_chan, ovf_clear,
        output rd_data, ovf
    );
endinterface

// File: rtl/accum_bank.sv
// Bank of CHANNELS unsigned WIDTH-bit accumulators with one add/sub/load/clear
// per cycle, wrap or saturate arithmetic, sticky overflow flags and a registered read.
module accum_bank #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic         clock,
    input logic         reset,
    accum_bank_if.slave bus
);
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [WIDTH-1:0]    acc     [CHANNELS];
    logic [WIDTH-1:0]    acc_nxt [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_nxt;
    logic [WIDTH-1:0]    rd_q, rd_nxt;

    logic             hit;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH:0]   sum, diff;
    logic             set_flag, clr_flag;
    op_e              op;

    // Matching against every real channel index makes an out-of-range
    // in_chan select nothing, so it naturally becomes a no-op.
    always_comb begin : operand_select
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        hit = 1'b0;
        cur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.in_chan == CW'(c)) begin
                hit = bus.in_valid;
                cur = acc[c];
            end
        end
    end

    assign op   = op_e'(bus.in_op);
    assign sum  = {1'b0, cur} + {1'b0, bus.in_arg};
    assign diff = {1'b0, cur} - {1'b0, bus.in_arg};

    // The top bit of the widened difference is the borrow (cur < in_arg).
    always_comb begin : op_decode
        new_val  = cur;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        unique case (op)
            OP_ADD: begin
                set_flag = sum[WIDTH];
                new_val  = (bus.sat_en && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                set_flag = diff[WIDTH];
                new_val  = (bus.sat_en && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            OP_LOAD: begin
                new_val = bus.in_arg;
            end
            OP_CLEAR: begin
                new_val  = '0;
                clr_flag = 1'b1;
            end
        endcase
    end

    // ovf_clear is applied first so a same-cycle carry/borrow wins over it.
    always_comb begin : next_state
        acc_nxt = acc;
        ovf_nxt = bus.ovf_clear ? '0 : ovf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (hit && bus.in_chan == CW'(c)) begin
                acc_nxt[c] = new_val;
                if (set_flag) begin
                    ovf_nxt[c] = 1'b1;
                end else if (clr_flag) begin
                    ovf_nxt[c] = 1'b0;
                end
            end
        end
    end

    // Read returns the pre-update value; out-of-range channels read as zero.
    always_comb begin : read_select
        rd_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.rd_chan == CW'(c)) begin
                rd_nxt = acc[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the accumulator array is deliberately reset, since clients
            // rely on every channel reading zero after reset; this keeps it in
            // flops rather than a RAM macro.
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
            ovf_q <= '0;
            rd_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            acc   <= acc_nxt;
            ovf_q <= ovf_nxt;
            rd_q  <= rd_nxt;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: a 4-channel and a 3-channel instance compared against
// an integer-arithmetic model of the accumulators, flags and read register.
module tb_accum_bank;
    localparam int MAXV = 255;

    logic clock = 1'b0;
    logic reset4 = 1'b1;
    logic reset3 = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    accum_bank_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
    accum_bank_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    accum_bank #(.WIDTH(8), .CHANNELS(4)) u_dut4 (.clock(clock), .reset(reset4), .bus(bus4));
    accum_bank #(.WIDTH(8), .CHANNELS(3)) u_dut3 (.clock(clock), .reset(reset3), .bus(bus3));

    always #5 clock = ~clock;

    // Model state, index 0 = 4-channel bank, index 1 = 3-channel bank.
    int m_acc [2][4];
    bit m_ovf [2][4];
    int m_rd  [2];
    int n_ch  [2] = '{4, 3};

    task automatic model_op(input int d, input bit rst, input bit v, input int ch, input int op,
                            input int arg, input bit sat, input int rd, input bit oclr);
        int s;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_acc[d][c] = 0;
                m_ovf[d][c] = 0;
            end
            m_rd[d] = 0;
            return;
        end
        m_rd[d] = (rd < n_ch[d]) ? m_acc[d][rd] : 0;
        if (oclr) for (int c = 0; c < 4; c++) m_ovf[d][c] = 0;
        if (v && ch < n_ch[d]) begin
            case (op)
                0: begin
                    s = m_acc[d][ch] + arg;
                    if (s > MAXV) begin
                        m_ovf[d][ch] = 1;
                        m_acc[d][ch] = sat ? MAXV : s - (MAXV + 1);
                    end else m_acc[d][ch] = s;
                end
                1: begin
                    if (arg > m_acc[d][ch]) begin
                        m_ovf[d][ch] = 1;
                        m_acc[d][ch] = sat ? 0 : m_acc[d][ch] - arg + MAXV + 1;
                    end else m_acc[d][ch] = m_acc[d][ch] - arg;
                end
                2: m_acc[d][ch] = arg;
                default: begin
                    m_acc[d][ch] = 0;
                    m_ovf[d][ch] = 0;
                end
            endcase
        end
    endtask

    function automatic logic [3:0] exp_ovf(input int d);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = (c < n_ch[d]) ? m_ovf[d][c] : 1'b0;
        return r;
    endfunction

    // One clock on the 4-channel bank; inputs return idle after the edge.
    task automatic step4(input bit rst, input bit v, input int ch, input int op, input int arg,
                         input bit sat, input int rd, input bit oclr);
        @(negedge clock);
        reset4 = rst;           bus4.in_valid  = v;
        bus4.in_chan = 2'(ch);  bus4.in_op     = 2'(op);
        bus4.in_arg  = 8'(arg); bus4.sat_en    = sat;
        bus4.rd_chan = 2'(rd);  bus4.ovf_clear = oclr;
        @(posedge clock);
        model_op(0, rst, v, ch, op, arg, sat, rd, oclr);
        #1;
        reset4 = 1'b0; bus4.in_valid = 1'b0; bus4.ovf_clear = 1'b0;
    endtask

    task automatic step3(input bit rst, input bit v, input int ch, input int op, input int arg,
                         input bit sat, input int rd, input bit oclr);
        @(negedge clock);
        reset3 = rst;           bus3.in_valid  = v;
        bus3.in_chan = 2'(ch);  bus3.in_op     = 2'(op);
        bus3.in_arg  = 8'(arg); bus3.sat_en    = sat;
        bus3.rd_chan = 2'(rd);  bus3.ovf_clear = oclr;
        @(posedge clock);
        model_op(1, rst, v, ch, op, arg, sat, rd, oclr);
        #1;
        reset3 = 1'b0; bus3.in_valid = 1'b0; bus3.ovf_clear = 1'b0;
    endtask

    task automatic test_reset;
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        step3(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step4(0, 0, 0, 0, 0, 0, c, 0);
            n_vec++;
            if (bus4.rd_data !== 8'd0 || bus4.ovf !== 4'b0000) begin
                n_miss++;
                $display("FAIL reset_sweep4 ch%0d: rd=%0d ovf=%b, want rd=0 ovf=0000", c, bus4.rd_data, bus4.ovf);
            end
            step3(0, 0, 0, 0, 0, 0, c, 0);
            n_vec++;
            if (bus3.rd_data !== 8'd0 || bus3.ovf !== 3'b000) begin
                n_miss++;
                $display("FAIL reset_sweep3 ch%0d: rd=%0d ovf=%b, want rd=0 ovf=000", c, bus3.rd_data, bus3.ovf);
            end
        end
        // Reset asserted in the middle of a stream of adds.
        for (int i = 0; i < 6; i++) step4(0, 1, i % 4, 0, $urandom_range(100, 255), 0, 0, 0);
        step4(1, 1, 1, 0, 50, 0, 1, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd0 || bus4.ovf !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_mid: rd=%0d ovf=%b, want rd=0 ovf=0000", bus4.rd_data, bus4.ovf);
        end
        for (int c = 0; c < 4; c++) begin
            step4(0, 0, 0, 0, 0, 0, c, 0);
            n_vec++;
            if (bus4.rd_data !== 8'd0) begin
                n_miss++;
                $display("FAIL reset_mid_acc%0d: got %0d want 0", c, bus4.rd_data);
            end
        end
    endtask

    task automatic test_wrap;
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        step4(0, 1, 1, 2, 250, 0, 0, 0);
        step4(0, 1, 1, 0, 10, 0, 0, 0);
        n_vec++;
        if (bus4.ovf !== 4'b0010) begin
            n_miss++;
            $display("FAIL wrap_ovf: got %b want 0010", bus4.ovf);
        end
        for (int c = 0; c < 4; c++) begin
            step4(0, 0, 0, 0, 0, 0, c, 0);
            n_vec++;
            if (bus4.rd_data !== ((c == 1) ? 8'd4 : 8'd0)) begin
                n_miss++;
                $display("FAIL wrap_acc%0d: got %0d want %0d", c, bus4.rd_data, (c == 1) ? 4 : 0);
            end
        end
    endtask

    task automatic test_saturate;
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        step4(0, 1, 2, 2, 250, 1, 0, 0);
        step4(0, 1, 2, 0, 10, 1, 0, 0);
        step4(0, 0, 0, 0, 0, 0, 2, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd255 || bus4.ovf !== 4'b0100) begin
            n_miss++;
            $display("FAIL sat_add: rd=%0d ovf=%b, want rd=255 ovf=0100", bus4.rd_data, bus4.ovf);
        end
        step4(0, 1, 2, 2, 5, 1, 0, 0);
        step4(0, 1, 2, 1, 9, 1, 0, 0);
        step4(0, 0, 0, 0, 0, 0, 2, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd0) begin
            n_miss++;
            $display("FAIL sat_sub: got %0d want 0", bus4.rd_data);
        end
        step4(0, 1, 2, 2, 5, 0, 0, 0);
        step4(0, 1, 2, 1, 9, 0, 0, 0);
        step4(0, 0, 0, 0, 0, 0, 2, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd252 || bus4.ovf !== 4'b0100) begin
            n_miss++;
            $display("FAIL wrap_sub: rd=%0d ovf=%b, want rd=252 ovf=0100", bus4.rd_data, bus4.ovf);
        end
    endtask

    task automatic test_collision;
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        step4(0, 1, 0, 2, 7, 0, 0, 0);
        step4(0, 1, 0, 0, 3, 0, 0, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd7) begin
            n_miss++;
            $display("FAIL collide_old: got %0d want 7", bus4.rd_data);
        end
        step4(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd10) begin
            n_miss++;
            $display("FAIL collide_new: got %0d want 10", bus4.rd_data);
        end
    endtask

    task automatic test_flags;
        logic [3:0] want [6] = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 4'b1010};
        int         ch   [6] = '{3, 0, 3, 0, 3, 1};
        int         op   [6] = '{0, 1, 0, 0, 0, 1};
        int         arg  [6] = '{100, 1, 100, 0, 250, 1};
        bit         v    [6] = '{1, 1, 1, 0, 1, 1};
        bit         oclr [6] = '{0, 0, 1, 1, 0, 0};
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) step4(0, 1, 3, 2, 200, 0, 0, 0);
            if (i == 1) step4(0, 1, 0, 2, 0, 0, 0, 0);
            if (i == 2) step4(0, 1, 3, 2, 200, 0, 0, 0);
            step4(0, v[i], ch[i], op[i], arg[i], 0, 0, oclr[i]);
            n_vec++;
            if (bus4.ovf !== want[i]) begin
                n_miss++;
                $display("FAIL flags_step%0d: got %b want %b", i, bus4.ovf, want[i]);
            end
        end
        step4(0, 1, 3, 3, 77, 0, 3, 0);
        step4(0, 0, 0, 0, 0, 0, 3, 0);
        n_vec++;
        if (bus4.rd_data !== 8'd0 || bus4.ovf !== 4'b0010) begin
            n_miss++;
            $display("FAIL flags_clear_op: rd=%0d ovf=%b, want rd=0 ovf=0010", bus4.rd_data, bus4.ovf);
        end
    endtask

    task automatic test_out_of_range;
        int want [4] = '{11, 22, 27, 0};
        step3(1, 0, 0, 0, 0, 0, 0, 0);
        step3(0, 1, 0, 2, 11, 0, 0, 0);
        step3(0, 1, 1, 2, 22, 0, 0, 0);
        step3(0, 1, 2, 2, 33, 0, 0, 0);
        step3(0, 1, 2, 0, 250, 0, 0, 0);
        step3(0, 1, 3, 0, 200, 0, 0, 0);
        step3(0, 1, 3, 3, 0, 0, 0, 0);
        step3(0, 1, 3, 2, 99, 1, 0, 0);
        n_vec++;
        if (bus3.ovf !== 3'b100) begin
            n_miss++;
            $display("FAIL oor_ovf: got %b want 100", bus3.ovf);
        end
        for (int c = 0; c < 4; c++) begin
            step3(0, 0, 0, 0, 0, 0, c, 0);
            n_vec++;
            if (bus3.rd_data !== 8'(want[c])) begin
                n_miss++;
                $display("FAIL oor_rd%0d: got %0d want %0d", c, bus3.rd_data, want[c]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] e;
        step4(1, 0, 0, 0, 0, 0, 0, 0);
        // Chained adds on one channel, each read sees the previous result.
        for (int i = 0; i < 8; i++) begin
            step4(0, 1, 2, 0, $urandom_range(0, 120), 1'($urandom_range(0, 1)), 2, 0);
            n_vec++;
            if (bus4.rd_data !== 8'(m_rd[0])) begin
                n_miss++;
                $display("FAIL chain%0d: got %0d want %0d", i, bus4.rd_data, m_rd[0]);
            end
        end
        for (int i = 0; i < 100; i++) begin
            step3(0, 1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0));
            e = exp_ovf(1);
            n_vec++;
            if (bus3.rd_data !== 8'(m_rd[1]) || bus3.ovf !== e[2:0]) begin
                n_miss++;
                $display("FAIL rand3_%0d: rd=%0d ovf=%b, want rd=%0d ovf=%b", i, bus3.rd_data, bus3.ovf, m_rd[1], e[2:0]);
            end
            step4(0, 1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0));
            e = exp_ovf(0);
            n_vec++;
            if (bus4.rd_data !== 8'(m_rd[0]) || bus4.ovf !== e) begin
                n_miss++;
                $display("FAIL rand4_%0d: rd=%0d ovf=%b, want rd=%0d ovf=%b", i, bus4.rd_data, bus4.ovf, m_rd[0], e);
            end
        end
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.in_chan = '0; bus4.in_op = '0; bus4.in_arg = '0;
        bus4.sat_en = 1'b0; bus4.rd_chan = '0; bus4.ovf_clear = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_chan = '0; bus3.in_op = '0; bus3.in_arg = '0;
        bus3.sat_en = 1'b0; bus3.rd_chan = '0; bus3.ovf_clear = 1'b0;
        test_reset;
        test_wrap;
        test_saturate;
        test_collision;
        test_flags;
        test_out_of_range;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
- Parametrised, multi-channel successor to the single 8-bit tick/tock accumulator submodule.
- Holds CHANNELS independent WIDTH-bit unsigned accumulators.
- Each cycle, at most one channel receives one operation: add, subtract, load or clear.
- Supports runtime-selectable wrap or saturate arithmetic, sticky per-channel overflow flags, and a registered read port.
- Instantiated by counters and statistics blocks that previously each owned a private accumulator submodule.

Parameters:
- WIDTH, 8, accumulator and operand width in bits (>=2).
- CHANNELS, 4, number of accumulators (>=1, need not be a power of two).
- CW, $clog2(CHANNELS) (min 1), channel index width; derived, not overridden.

Ports:
- clock  input  1  global clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation strobe; ignored when low.
- in_chan  input  CW  target channel.
- in_op  input  2  operation: 00 add, 01 sub, 10 load, 11 clear.
- in_arg  input  WIDTH  unsigned operand; ignored for clear.
- sat_en  input  1  1 = saturate, 0 = wrap; sampled with in_valid.
- rd_chan  input  CW  read channel select.
- rd_data  output  WIDTH  registered accumulator value.
- ovf  output  CHANNELS  sticky overflow/underflow flag per channel.
- ovf_clear  input  1  clears all ovf bits.

Behaviour:
- Reset:
  - When reset is high at a clock edge, all accumulators, rd_data and ovf are set to 0.
  - Reset overrides every other input that cycle.
  - Reset mid-sequence discards any operation presented in the same cycle.
- Single-cycle update: for in_valid=1 and in_chan < CHANNELS, acc[in_chan] takes its new value at this edge, per in_op:
  - add: sum computed WIDTH+1 bits wide; carry = bit WIDTH.
    - wrap: acc <= sum[WIDTH-1:0].
    - saturate: acc <= carry ? all-ones : sum.
  - sub: diff computed WIDTH+1 bits wide; borrow = acc < in_arg.
    - wrap: acc <= (acc - in_arg) mod 2^WIDTH.
    - saturate: acc <= borrow ? 0 : acc - in_arg.
  - load: acc <= in_arg; flags unaffected.
  - clear: acc <= 0 and ovf[in_chan] <= 0.
- Overflow flags:
  - ovf[c] is set on carry (add) or borrow (sub) for channel c, independent of sat_en.
  - Sticky until ovf_clear, clear op on c, or reset.
  - ovf_clear together with a new carry/borrow on c in the same cycle: ovf[c] ends at 1 (set wins).
  - ovf_clear affects all channels; a clear op affects only its own channel.
- Out-of-range channel: in_valid with in_chan >= CHANNELS is a no-op, with no flag change. The same rule applies to rd_chan: rd_data <= 0.
- No channel interaction: untargeted channels always hold their value.
- Read port:
  - rd_data <= acc[rd_chan] value before this edge's update, so latency is one cycle and the result is pre-update.
  - A read and a write to the same channel in the same cycle returns the old value; the new value is visible on the read issued the following cycle.
- No backpressure: in_valid is accepted every cycle; back-to-back ops on one channel chain correctly (each sees the previous result).
- Arithmetic is unsigned only; no sign extension anywhere.

Test Plan:
- Reset then rd_chan sweep 0..3 -> rd_data=0 for each read and ovf=4'b0000; assert reset during a stream of adds -> all state 0 on the next cycle.
- Wrap add, ch1: load 250, then add 10 with sat_en=0 -> acc1=4 and ovf[1]=1; other channels remain 0.
- Saturate, ch2:
  - load 250, add 10 with sat_en=1 -> acc2=255, ovf[2]=1.
  - load 5, sub 9 with sat_en=1 -> acc2=0.
  - With sat_en=0, the same sub gives acc2=252.
- Read/write collision:
  - cycle t: add 3 to ch0 (acc0=7), with rd_chan=0 -> rd_data at t+1 = 7.
  - Read issued at t+1 -> rd_data at t+2 = 10.
- Flag priority: ovf[3]=1; in one cycle apply ovf_clear plus a carry-producing add on ch3 -> ovf[3]=1. Next cycle ovf_clear alone -> ovf[3]=0. A clear op on ch3 -> acc3=0 and ovf[3]=0.
- CHANNELS=3 build: op on in_chan=3 -> no state change; rd_chan=3 -> rd_data=0; 100 back-to-back random ops -> match a scoreboard model.
